// File: rtl/csr_unit.sv
// Machine-mode CSR file with a RUN/SLEEP/TRAP sequencer for external-interrupt traps, WFI and MRET.
// Optional 64-bit mcycle/minstret counters are built only when CSR_COUNTER_EN is defined.
module csr_unit #(
   parameter int                DATA_W    = 32,
   parameter logic [DATA_W-1:0] MTVEC_RST = 32'h0000_1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              csr_read,
   input  logic              csr_write,
   input  logic [1:0]        csr_op,
   input  logic [11:0]       csr_addr,
   input  logic [DATA_W-1:0] csr_wdata,
   input  logic              wfi_req,
   input  logic              mret_req,
   input  logic              ext_irq,
   input  logic [DATA_W-1:0] pc_epc,
   input  logic              instret_inc,
   output logic [DATA_W-1:0] csr_rdata,
   output logic              interrupt,
   output logic              sleep,
   output logic              trap_taken,
   output logic [DATA_W-1:0] trap_pc,
   output logic              mret_taken,
   output logic [DATA_W-1:0] mepc_out
);

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MIE     = 12'h304;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam logic [11:0] ADDR_MIP     = 12'h344;
   localparam logic [DATA_W-1:0] MCAUSE_MEI = {1'b1, {(DATA_W-5){1'b0}}, 4'hB};
   localparam logic [DATA_W-1:0] EPC_MASK   = {{(DATA_W-2){1'b1}}, 2'b00};

   typedef enum logic [1:0] {ST_RUN, ST_SLEEP, ST_TRAP} state_t;

   state_t            r_state, w_state_nxt;
   logic              r_mstatus_mie, r_mstatus_mpie, r_mie_meie;
   logic              r_irq_sync, r_mip_meip, r_mret_taken;
   logic [DATA_W-1:0] r_mtvec, r_mepc, r_mcause;
   logic [DATA_W-1:0] w_csr_val, w_csr_new;
   logic              w_wr_en, w_take, w_do_trap, w_do_mret;

   function automatic logic [DATA_W-1:0] csr_apply(input logic [1:0]        op,
                                                   input logic [DATA_W-1:0] old_v,
                                                   input logic [DATA_W-1:0] wd);
      case (op)
         2'b01:   csr_apply = wd;
         2'b10:   csr_apply = old_v | wd;
         2'b11:   csr_apply = old_v & ~wd;
         default: csr_apply = old_v;
      endcase
   endfunction

`ifdef CSR_COUNTER_EN
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
   localparam logic [2*DATA_W-1:0] CNT_ONE = {{(2*DATA_W-1){1'b0}}, 1'b1};
   logic [2*DATA_W-1:0] r_mcycle, r_minstret;
`else
   // Kept only so the retire strobe is not flagged as dangling in this build.
   logic w_unused_instret;
   assign w_unused_instret = instret_inc;
`endif

   // Read mux is also the "old" operand for set/clear writes.
   always_comb begin
      w_csr_val = '0;
      case (csr_addr)
         ADDR_MSTATUS: begin
            w_csr_val[12:11] = 2'b11;
            w_csr_val[7]     = r_mstatus_mpie;
            w_csr_val[3]     = r_mstatus_mie;
         end
         ADDR_MIE:     w_csr_val[11] = r_mie_meie;
         ADDR_MTVEC:   w_csr_val = r_mtvec;
         ADDR_MEPC:    w_csr_val = r_mepc;
         ADDR_MCAUSE:  w_csr_val = r_mcause;
         ADDR_MIP:     w_csr_val[11] = r_mip_meip;
`ifdef CSR_COUNTER_EN
         ADDR_MCYCLE:    w_csr_val = r_mcycle[DATA_W-1:0];
         ADDR_MCYCLEH:   w_csr_val = r_mcycle[2*DATA_W-1:DATA_W];
         ADDR_MINSTRET:  w_csr_val = r_minstret[DATA_W-1:0];
         ADDR_MINSTRETH: w_csr_val = r_minstret[2*DATA_W-1:DATA_W];
`endif
         default:      w_csr_val = '0;
      endcase
   end

   assign csr_rdata  = (csr_read && !rst) ? w_csr_val : '0;
   assign w_csr_new  = csr_apply(csr_op, w_csr_val, csr_wdata);
   assign w_wr_en    = csr_write && (csr_op != 2'b00);
   assign interrupt  = r_mip_meip & r_mie_meie;
   assign w_take     = interrupt & r_mstatus_mie;
   assign w_do_mret  = (r_state == ST_RUN) && mret_req;
   assign w_do_trap  = (w_state_nxt == ST_TRAP) && (r_state != ST_TRAP);
   assign sleep      = (r_state == ST_SLEEP);
   assign trap_taken = (r_state == ST_TRAP);
   assign mret_taken = r_mret_taken;
   assign trap_pc    = r_mtvec & EPC_MASK;
   assign mepc_out   = r_mepc;

   // MRET has priority over a trap in RUN; the trap is re-evaluated next cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN: begin
            if (mret_req)                    w_state_nxt = ST_RUN;
            else if (w_take)                 w_state_nxt = ST_TRAP;
            else if (wfi_req && !interrupt)  w_state_nxt = ST_SLEEP;
         end
         ST_SLEEP: begin
            if (w_take)                      w_state_nxt = ST_TRAP;
            else if (interrupt)              w_state_nxt = ST_RUN;
         end
         ST_TRAP:                            w_state_nxt = ST_RUN;
         default:                            w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= ST_RUN;
         r_irq_sync     <= 1'b0;
         r_mip_meip     <= 1'b0;
         r_mret_taken   <= 1'b0;
         r_mstatus_mie  <= 1'b0;
         r_mstatus_mpie <= 1'b0;
         r_mie_meie     <= 1'b0;
         r_mtvec        <= MTVEC_RST;
         r_mepc         <= '0;
         r_mcause       <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_irq_sync   <= ext_irq;
         r_mip_meip   <= r_irq_sync;
         r_mret_taken <= w_do_mret;
         // Hardware trap/return updates beat a software write to the same CSR.
         if (w_do_trap) begin
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
         end else if (w_do_mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
         end else if (w_wr_en && csr_addr == ADDR_MSTATUS) begin
            r_mstatus_mie  <= w_csr_new[3];
            r_mstatus_mpie <= w_csr_new[7];
         end
         if (w_do_trap) begin
            r_mepc   <= pc_epc & EPC_MASK;
            r_mcause <= MCAUSE_MEI;
         end else if (w_wr_en) begin
            if (csr_addr == ADDR_MEPC)   r_mepc   <= w_csr_new & EPC_MASK;
            if (csr_addr == ADDR_MCAUSE) r_mcause <= w_csr_new;
         end
         if (w_wr_en && csr_addr == ADDR_MIE)   r_mie_meie <= w_csr_new[11];
         if (w_wr_en && csr_addr == ADDR_MTVEC) r_mtvec    <= w_csr_new;
      end
   end

`ifdef CSR_COUNTER_EN
   // A software write to either half suppresses that cycle's increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mcycle   <= '0;
         r_minstret <= '0;
      end else begin
         if (w_wr_en && csr_addr == ADDR_MCYCLE)
            r_mcycle[DATA_W-1:0] <= w_csr_new;
         else if (w_wr_en && csr_addr == ADDR_MCYCLEH)
            r_mcycle[2*DATA_W-1:DATA_W] <= w_csr_new;
         else
            r_mcycle <= r_mcycle + CNT_ONE;
         if (w_wr_en && csr_addr == ADDR_MINSTRET)
            r_minstret[DATA_W-1:0] <= w_csr_new;
         else if (w_wr_en && csr_addr == ADDR_MINSTRETH)
            r_minstret[2*DATA_W-1:DATA_W] <= w_csr_new;
         else if (instret_inc)
            r_minstret <= r_minstret + CNT_ONE;
      end
   end
`endif

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: table of CSR write/readback vectors plus trap, MRET, WFI,
// priority and reset sequences; read data goes through an expected-value queue.
module tb_csr_unit;

   logic        clk, rst;
   logic        csr_read, csr_write;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata, pc_epc;
   logic        wfi_req, mret_req, ext_irq, instret_inc;
   logic [31:0] csr_rdata, trap_pc, mepc_out;
   logic        interrupt, sleep, trap_taken, mret_taken;

   int total = 0;
   int bad   = 0;
   logic [31:0] sb_q[$];

   typedef struct {
      logic [11:0] addr;
      logic [1:0]  op;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t vt[13];

   csr_unit dut (
      .clk(clk), .rst(rst), .csr_read(csr_read), .csr_write(csr_write), .csr_op(csr_op),
      .csr_addr(csr_addr), .csr_wdata(csr_wdata), .wfi_req(wfi_req), .mret_req(mret_req),
      .ext_irq(ext_irq), .pc_epc(pc_epc), .instret_inc(instret_inc), .csr_rdata(csr_rdata),
      .interrupt(interrupt), .sleep(sleep), .trap_taken(trap_taken), .trap_pc(trap_pc),
      .mret_taken(mret_taken), .mepc_out(mepc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic sb_pop(input string nm, input logic [31:0] act);
      logic [31:0] e;
      if (sb_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: got %h want <none queued>", nm, act);
      end else begin
         e = sb_q.pop_front();
         chk(nm, act, e);
      end
   endtask

   task automatic sb_read(input string nm, input logic [11:0] a, input logic [31:0] e);
      csr_read = 1'b1;
      csr_addr = a;
      sb_q.push_back(e);
      @(negedge clk);
      sb_pop(nm, csr_rdata);
      csr_read = 1'b0;
   endtask

   task automatic csr_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
      csr_write = 1'b1;
      csr_addr  = a;
      csr_op    = op;
      csr_wdata = wd;
      @(posedge clk);
      #1;
      csr_write = 1'b0;
      csr_op    = 2'b00;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      vt[0]  = '{12'h305, 2'b01, 32'h0000_2000, 32'h0000_2000};
      vt[1]  = '{12'h305, 2'b10, 32'h0000_0003, 32'h0000_2003};
      vt[2]  = '{12'h305, 2'b11, 32'h0000_0001, 32'h0000_2002};
      vt[3]  = '{12'h305, 2'b00, 32'h0000_FFFF, 32'h0000_2002};
      vt[4]  = '{12'h304, 2'b01, 32'hFFFF_FFFF, 32'h0000_0800};
      vt[5]  = '{12'h304, 2'b11, 32'h0000_0800, 32'h0000_0000};
      vt[6]  = '{12'h300, 2'b01, 32'hFFFF_FFFF, 32'h0000_1888};
      vt[7]  = '{12'h300, 2'b11, 32'h0000_0088, 32'h0000_1800};
      vt[8]  = '{12'h341, 2'b01, 32'h0000_0147, 32'h0000_0144};
      vt[9]  = '{12'h342, 2'b01, 32'h1234_5678, 32'h1234_5678};
      vt[10] = '{12'h344, 2'b10, 32'h0000_0800, 32'h0000_0000};
      vt[11] = '{12'hF14, 2'b01, 32'hDEAD_BEEF, 32'h0000_0000};
      vt[12] = '{12'h123, 2'b01, 32'hCAFE_F00D, 32'h0000_0000};

      rst = 1'b1; csr_read = 1'b1; csr_write = 1'b0; csr_op = 2'b00; csr_addr = 12'h300;
      csr_wdata = '0; pc_epc = '0; wfi_req = 1'b0; mret_req = 1'b0; ext_irq = 1'b0;
      instret_inc = 1'b0;
      #12;
      chk("rst_rdata", csr_rdata, 32'h0);
      chk("rst_sleep", {31'b0, sleep}, 32'h0);
      chk("rst_trap", {31'b0, trap_taken}, 32'h0);
      chk("rst_mret", {31'b0, mret_taken}, 32'h0);
      csr_read = 1'b0;
      @(posedge clk); #1 rst = 1'b0;

      sb_read("rst_mtvec", 12'h305, 32'h0000_1000);
      sb_read("rst_mstatus", 12'h300, 32'h0000_1800);
      sb_read("rst_mie", 12'h304, 32'h0);
      sb_read("rst_mcause", 12'h342, 32'h0);
      chk("rst_trap_pc", trap_pc, 32'h0000_1000);
      chk("rst_mepc_out", mepc_out, 32'h0);
      chk("rst_interrupt", {31'b0, interrupt}, 32'h0);

      for (int i = 0; i < 13; i++) begin
         csr_wr(vt[i].addr, vt[i].op, vt[i].wdata);
         sb_read($sformatf("vec%0d", i), vt[i].addr, vt[i].exp);
         if (vt[i].addr == 12'h305) chk($sformatf("vec%0d_trap_pc", i), trap_pc, vt[i].exp & ~32'h3);
      end

      // Trap entry: 3 edges from ext_irq rising to the trap pulse.
      csr_wr(12'h304, 2'b01, 32'h800);
      csr_wr(12'h300, 2'b01, 32'h8);
      pc_epc = 32'h0000_0140;
      @(posedge clk); #1 ext_irq = 1'b1;
      @(negedge clk); chk("irq_edge_n", {31'b0, interrupt}, 32'h0);
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      chk("irq_edge_n2", {31'b0, interrupt}, 32'h1);
      chk("trap_early", {31'b0, trap_taken}, 32'h0);
      @(negedge clk);
      chk("trap_pulse", {31'b0, trap_taken}, 32'h1);
      chk("trap_mepc_out", mepc_out, 32'h140);
      @(negedge clk); chk("trap_one_cycle", {31'b0, trap_taken}, 32'h0);
      sb_read("trap_mepc", 12'h341, 32'h140);
      sb_read("trap_mcause", 12'h342, 32'h8000_000B);
      sb_read("trap_mstatus", 12'h300, 32'h0000_1880);

      ext_irq = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); chk("irq_cleared", {31'b0, interrupt}, 32'h0);
      mret_req = 1'b1;
      @(posedge clk); #1 mret_req = 1'b0;
      sb_read("mret_mstatus", 12'h300, 32'h0000_1888);
      chk("mret_pulse", {31'b0, mret_taken}, 32'h1);
      chk("mret_mepc_out", mepc_out, 32'h140);
      @(negedge clk); chk("mret_one_cycle", {31'b0, mret_taken}, 32'h0);

      // WFI with MIE=0: interrupt wakes the core without trapping.
      csr_wr(12'h300, 2'b01, 32'h0);
      wfi_req = 1'b1;
      @(posedge clk); #1 wfi_req = 1'b0;
      @(negedge clk); chk("wfi_sleep", {31'b0, sleep}, 32'h1);
      @(posedge clk); #1 ext_irq = 1'b1;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      chk("wfi_irq", {31'b0, interrupt}, 32'h1);
      chk("wfi_still_sleep", {31'b0, sleep}, 32'h1);
      @(negedge clk);
      chk("wfi_wake", {31'b0, sleep}, 32'h0);
      chk("wfi_no_trap", {31'b0, trap_taken}, 32'h0);
      @(negedge clk); chk("wfi_no_trap2", {31'b0, trap_taken}, 32'h0);
      wfi_req = 1'b1;
      @(posedge clk); #1 wfi_req = 1'b0;
      @(negedge clk); chk("wfi_nop", {31'b0, sleep}, 32'h0);

      // Same-cycle MRET, trap and software mstatus write.
      ext_irq = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      csr_wr(12'h300, 2'b01, 32'h88);
      pc_epc = 32'h0000_0203;
      @(negedge clk); chk("prio_irq_low", {31'b0, interrupt}, 32'h0);
      @(posedge clk); #1 ext_irq = 1'b1;
      @(posedge clk); @(posedge clk);
      #1;
      chk("prio_irq_high", {31'b0, interrupt}, 32'h1);
      mret_req = 1'b1; csr_write = 1'b1; csr_addr = 12'h300; csr_op = 2'b01; csr_wdata = 32'h0;
      @(posedge clk); #1;
      mret_req = 1'b0; csr_write = 1'b0; csr_op = 2'b00;
      sb_read("prio_mstatus", 12'h300, 32'h0000_1888);
      chk("prio_mret", {31'b0, mret_taken}, 32'h1);
      chk("prio_no_trap", {31'b0, trap_taken}, 32'h0);
      @(negedge clk);
      chk("prio_trap_next", {31'b0, trap_taken}, 32'h1);
      chk("prio_mepc", mepc_out, 32'h200);
      sb_read("prio_mstatus_after", 12'h300, 32'h0000_1880);

      // Reset during TRAP: pulse drops at once.
      csr_wr(12'h300, 2'b01, 32'h8);
      @(posedge clk);
      @(negedge clk); chk("rt_trap", {31'b0, trap_taken}, 32'h1);
      #1 rst = 1'b1;
      #1;
      chk("rt_trap_cleared", {31'b0, trap_taken}, 32'h0);
      chk("rt_mepc_cleared", mepc_out, 32'h0);
      ext_irq = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      sb_read("rt_mstatus", 12'h300, 32'h0000_1800);
      chk("rt_no_pulse", {31'b0, trap_taken}, 32'h0);

      // Reset during SLEEP.
      csr_wr(12'h304, 2'b01, 32'h800);
      wfi_req = 1'b1;
      @(posedge clk); #1 wfi_req = 1'b0;
      @(negedge clk); chk("rs_sleep", {31'b0, sleep}, 32'h1);
      #2 rst = 1'b1;
      #1 chk("rs_sleep_cleared", {31'b0, sleep}, 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      sb_read("rs_mie", 12'h304, 32'h0);
      chk("rs_no_sleep", {31'b0, sleep}, 32'h0);

`ifdef CSR_COUNTER_EN
      csr_write = 1'b1; csr_op = 2'b01; csr_addr = 12'hB00; csr_wdata = 32'hFFFF_FFFE;
      @(posedge clk); #1;
      csr_addr = 12'hB80; csr_wdata = 32'h0;
      @(posedge clk); #1;
      csr_write = 1'b0; csr_op = 2'b00;
      @(posedge clk); @(posedge clk); #1;
      csr_read = 1'b1; csr_addr = 12'hB80; sb_q.push_back(32'h1);
      #2 sb_pop("mcycleh_carry", csr_rdata);
      csr_addr = 12'hB00; sb_q.push_back(32'h0);
      #2 sb_pop("mcycle_wrap", csr_rdata);
      csr_read = 1'b0;
      instret_inc = 1'b1;
      csr_wr(12'hB02, 2'b01, 32'h5);
      @(posedge clk); #1 instret_inc = 1'b0;
      sb_read("minstret", 12'hB02, 32'h6);
`else
      csr_wr(12'hB00, 2'b01, 32'h1234);
      sb_read("nocnt_mcycle", 12'hB00, 32'h0);
      sb_read("nocnt_mcycleh", 12'hB80, 32'h0);
`endif

      if (sb_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
